// File: rtl/irq_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACK     = 2'd2
  } irq_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int src_idx(input int b, input int c, input int num_ch);
    return b * num_ch + c;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest bus wins, then lowest channel within that bus.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_BUS = 3,
  parameter int NUM_CH  = 9,
  parameter int BUS_W   = clog2_min1(NUM_BUS),
  parameter int CH_W    = clog2_min1(NUM_CH)
) (
  input  logic [NUM_BUS*NUM_CH-1:0] elig,
  output logic                      any,
  output logic [BUS_W-1:0]          bus,
  output logic [CH_W-1:0]           ch
);

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    any = 1'b0;
    bus = '0;
    ch  = '0;
    for (int b = NUM_BUS - 1; b >= 0; b--) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (elig[src_idx(b, c, NUM_CH)]) begin
          any = 1'b1;
          bus = BUS_W'(b);
          ch  = CH_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Clocked priority interrupt controller: pending capture, fixed-priority
// arbitration and a registered winner under a valid/ack handshake.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_BUS   = 3,
  parameter int NUM_CH    = 9,
  parameter int EDGE_MODE = 0,
  parameter int BUS_W     = clog2_min1(NUM_BUS),
  parameter int CH_W      = clog2_min1(NUM_CH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_BUS*NUM_CH-1:0]              req,
  input  logic [NUM_BUS*NUM_CH-1:0]              en,
  input  logic                                   ack,
  output logic                                   irq_valid,
  output logic [BUS_W-1:0]                       irq_bus,
  output logic [CH_W-1:0]                        irq_ch,
  output logic [NUM_BUS-1:0]                     bus_pend,
  output logic [$clog2(NUM_BUS*NUM_CH+1)-1:0]    pend_cnt
);

  localparam int NSRC  = NUM_BUS * NUM_CH;
  localparam int CNT_W = $clog2(NSRC + 1);

  logic [NSRC-1:0] pend, pend_nx, req_q, set, clr, elig;
  logic            armed;
  irq_state_e      state, state_nx;
  logic [BUS_W-1:0] bus_nx, win_bus;
  logic [CH_W-1:0]  ch_nx, win_ch;
  logic             win_any;

  // A request already high when reset is released is not a new edge, so
  // edge detection is held off for the first clock after reset.
  assign set = armed ? (req & ~req_q) : '0;

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign clr[src_idx(b, c, NUM_CH)] = (state == ACK) &&
                                          (irq_bus == BUS_W'(b)) &&
                                          (irq_ch == CH_W'(c));
    end
    assign bus_pend[b] = |elig[b*NUM_CH +: NUM_CH];
  end

  // Set is OR'd after the clear so a fresh edge on the acked source survives.
  assign pend_nx = (EDGE_MODE != 0) ? ((pend & ~clr) | set) : req;
  assign elig    = pend & en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      req_q <= '0;
      armed <= 1'b0;
    end else begin
      pend  <= pend_nx;
      req_q <= req;
      armed <= 1'b1;
    end
  end

  irq_prio_enc #(
    .NUM_BUS (NUM_BUS),
    .NUM_CH  (NUM_CH),
    .BUS_W   (BUS_W),
    .CH_W    (CH_W)
  ) u_enc (
    .elig (elig),
    .any  (win_any),
    .bus  (win_bus),
    .ch   (win_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      irq_bus <= '0;
      irq_ch  <= '0;
    end else begin
      state   <= state_nx;
      irq_bus <= bus_nx;
      irq_ch  <= ch_nx;
    end
  end

  // Winner is only captured in IDLE, so the presented index never moves.
  always_comb begin
    state_nx = state;
    bus_nx   = irq_bus;
    ch_nx    = irq_ch;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_nx = PRESENT;
          bus_nx   = win_bus;
          ch_nx    = win_ch;
        end
      end
      PRESENT: if (ack) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign irq_valid = (state == PRESENT);

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NSRC; i++) pend_cnt = pend_cnt + CNT_W'(elig[i]);
  end

endmodule
